// File: rtl/rbsp_epb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rbsp_epb_buffer_pkg
// Brief    : Shared constants and helpers for the RBSP emulation-prevention
//            byte buffer (buffer geometry, EPB pattern, consume clamp).
// Revision : 1.0 - initial release
// ============================================================================
package rbsp_epb_buffer_pkg;

    localparam int          RBSP_BUF_W   = 64;
    localparam int          RBSP_WIN_W   = 32;
    localparam logic [7:0]  EPB_BYTE     = 8'h03;
    localparam int          EPB_ZERO_RUN = 2;

    // Largest consume request honoured in one cycle; larger requests clamp.
    localparam logic [5:0]  RBSP_MAX_FWD = 6'd32;

    // Clamp a requested forward length to the window width.
    function automatic logic [5:0] clamp_forward_len(input logic [5:0] len);
        return (len > RBSP_MAX_FWD) ? RBSP_MAX_FWD : len;
    endfunction

endpackage : rbsp_epb_buffer_pkg
`default_nettype wire

// File: rtl/rbsp_epb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : rbsp_epb_buffer_if
// Brief    : Stream-memory byte bus plus the RBSP look-ahead window bus that
//            the buffer presents to the bitstream controller and parsers.
// Revision : 1.0 - initial release
// ============================================================================
interface rbsp_epb_buffer_if;

    // Byte side (stream memory)
    logic [7:0] stream_mem_data;
    logic       stream_mem_valid;
    logic       stream_mem_rd;

    // Bit side (parsers)
    logic [5:0] forward_len;
    logic [31:0] rbsp_out;
    logic       rbsp_buffer_valid;
    logic [6:0] bit_count;

    // Producer of bytes / consumer of bits
    modport master (
        output stream_mem_data,
        output stream_mem_valid,
        input  stream_mem_rd,
        output forward_len,
        input  rbsp_out,
        input  rbsp_buffer_valid,
        input  bit_count
    );

    // The buffer itself
    modport slave (
        input  stream_mem_data,
        input  stream_mem_valid,
        output stream_mem_rd,
        input  forward_len,
        output rbsp_out,
        output rbsp_buffer_valid,
        output bit_count
    );

endinterface : rbsp_epb_buffer_if
`default_nettype wire

// File: rtl/rbsp_epb_buffer_epb_detector.sv
`default_nettype none
// ============================================================================
// Module   : epb_detector
// Brief    : Tracks the run of 0x00 bytes in the raw stream and flags a 0x03
//            that follows two zeros as an emulation-prevention byte to drop.
// Revision : 1.0 - initial release
// ============================================================================
module epb_detector
    import rbsp_epb_buffer_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_ena,
    input  wire logic       i_flush,
    input  wire logic       i_accept,
    input  wire logic [7:0] i_data,
    output logic            o_drop
);

    localparam logic [1:0] c_ZERO_RUN_MAX = 2'(EPB_ZERO_RUN);

    logic [1:0] r_zero_run;
    logic       w_drop;

    // Drop decision from the zero-run history and the byte on the bus now.
    always_comb begin
        w_drop = (r_zero_run == c_ZERO_RUN_MAX) && (i_data == EPB_BYTE);
    end

    assign o_drop = w_drop;

    // Zero-run history: advances on accepted bytes only, saturating at two
    // so that 00 00 00 03 still marks the 03 for removal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero_run <= 2'd0;
        end else if (i_ena) begin
            if (i_flush) begin
                r_zero_run <= 2'd0;
            end else if (i_accept) begin
                if (w_drop) begin
                    r_zero_run <= 2'd0;
                end else if (i_data == 8'h00) begin
                    r_zero_run <= (r_zero_run == c_ZERO_RUN_MAX) ? r_zero_run
                                                                 : r_zero_run + 2'd1;
                end else begin
                    r_zero_run <= 2'd0;
                end
            end
        end
    end

endmodule : epb_detector
`default_nettype wire

// File: rtl/rbsp_epb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rbsp_epb_buffer
// Brief    : Pulls raw NAL bytes, removes emulation-prevention bytes and packs
//            the RBSP bits into a left-aligned 64-bit shift buffer, presenting
//            a 32-bit look-ahead window to the parsers.
// Revision : 1.0 - initial release
// ============================================================================
module rbsp_epb_buffer
    import rbsp_epb_buffer_pkg::*;
#(
    parameter int BUF_W = RBSP_BUF_W,
    parameter int WIN_W = RBSP_WIN_W
)
(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          ena,
    input  wire logic          flush,
    output logic               epb_removed,
    rbsp_epb_buffer_if.slave   bus
);

    // A byte fits only while at least eight free bit positions remain.
    localparam logic [6:0] c_FILL_MAX = 7'(BUF_W - 8);
    localparam logic [6:0] c_WIN_BITS = 7'(WIN_W);

    logic [BUF_W-1:0] r_buffer;
    logic [6:0]       r_bit_count;
    logic             r_epb_removed;

    logic             w_rd;
    logic             w_accept;
    logic             w_drop;
    logic             w_kept;
    logic             w_valid;
    logic [5:0]       w_fl;
    logic [6:0]       w_rem;
    logic [BUF_W-1:0] w_shifted;
    logic [BUF_W-1:0] w_insert;
    logic [BUF_W-1:0] w_next_buffer;
    logic [6:0]       w_next_count;

    epb_detector u_epb_detector (
        .clk      (clk),
        .rst      (rst),
        .i_ena    (ena),
        .i_flush  (flush),
        .i_accept (w_accept),
        .i_data   (bus.stream_mem_data),
        .o_drop   (w_drop)
    );

    // Accept/consume decisions and the shifted-plus-inserted next buffer.
    always_comb begin
        w_rd          = ena && !flush && (r_bit_count <= c_FILL_MAX);
        w_accept      = w_rd && bus.stream_mem_valid;
        w_kept        = w_accept && !w_drop;
        w_valid       = (r_bit_count >= c_WIN_BITS);
        // Bits are only consumed from a window that is actually full.
        w_fl          = (ena && w_valid) ? clamp_forward_len(bus.forward_len) : 6'd0;
        w_rem         = r_bit_count - {1'b0, w_fl};
        w_shifted     = r_buffer << w_fl;
        // New byte lands directly after the remaining bits, MSB first.
        w_insert      = {bus.stream_mem_data, {(BUF_W-8){1'b0}}} >> w_rem;
        w_next_buffer = w_kept ? (w_shifted | w_insert) : w_shifted;
        w_next_count  = w_rem + (w_kept ? 7'd8 : 7'd0);
    end

    // Buffer, fill level and EPB pulse; everything holds while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buffer      <= '0;
            r_bit_count   <= 7'd0;
            r_epb_removed <= 1'b0;
        end else if (ena) begin
            if (flush) begin
                r_buffer      <= '0;
                r_bit_count   <= 7'd0;
                r_epb_removed <= 1'b0;
            end else begin
                r_buffer      <= w_next_buffer;
                r_bit_count   <= w_next_count;
                r_epb_removed <= w_accept && w_drop;
            end
        end
    end

    assign bus.stream_mem_rd     = w_rd;
    assign bus.rbsp_out          = r_buffer[BUF_W-1 -: WIN_W];
    assign bus.rbsp_buffer_valid = w_valid;
    assign bus.bit_count         = r_bit_count;
    assign epb_removed           = r_epb_removed;

endmodule : rbsp_epb_buffer
`default_nettype wire

// File: tb/tb_rbsp_epb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbsp_epb_buffer
// Brief    : Directed self-checking bench for rbsp_epb_buffer. A bit-queue
//            reference model predicts each cycle's outputs into a scoreboard
//            that is popped and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rbsp_epb_buffer;

    typedef struct {
        logic [31:0] out;
        logic [6:0]  cnt;
        logic        vld;
        logic        epb;
    } exp_t;

    logic clk;
    logic rst;
    logic ena;
    logic flush;
    logic epb_removed;

    rbsp_epb_buffer_if bus_if ();

    rbsp_epb_buffer #(.BUF_W(64), .WIN_W(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .flush       (flush),
        .epb_removed (epb_removed),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_assert;
    int   n_fail;
    exp_t sb[$];

    // Reference model: the RBSP bit stream as a plain queue of bits
    bit   mq[$];
    int   mzr;
    logic mepb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model_out();
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++)
            if (i < mq.size()) o[31-i] = mq[i];
        return o;
    endfunction

    task automatic model_reset();
        mq.delete();
        mzr  = 0;
        mepb = 1'b0;
    endtask

    task automatic check_now(input string tag);
        chk({tag, "_out"}, 64'(bus_if.rbsp_out), 64'(model_out()));
        chk({tag, "_cnt"}, 64'(bus_if.bit_count), 64'(mq.size()));
        chk({tag, "_vld"}, 64'(bus_if.rbsp_buffer_valid), 64'(mq.size() >= 32));
        chk({tag, "_epb"}, 64'(epb_removed), 64'(mepb));
    endtask

    // One clock of stimulus: drive, check the accept strobe, predict, clock, compare.
    task automatic step(input logic en, input logic fls, input logic vld,
                        input logic [7:0] d, input logic [5:0] f);
        logic exp_rd;
        logic acc;
        logic dropped;
        int   fle;
        exp_t e;
        ena = en; flush = fls;
        bus_if.stream_mem_valid = vld;
        bus_if.stream_mem_data  = d;
        bus_if.forward_len      = f;
        #1;
        exp_rd = en && !fls && (mq.size() <= 56);
        chk("stream_mem_rd", 64'(bus_if.stream_mem_rd), 64'(exp_rd));
        if (en) begin
            if (fls) begin
                model_reset();
            end else begin
                acc = exp_rd && vld;
                fle = (mq.size() >= 32) ? ((f > 6'd32) ? 32 : int'(f)) : 0;
                repeat (fle) void'(mq.pop_front());
                dropped = acc && (mzr == 2) && (d == 8'h03);
                if (acc && !dropped)
                    for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
                if (acc) mzr = dropped ? 0 : ((d == 8'h00) ? ((mzr == 2) ? 2 : mzr + 1) : 0);
                mepb = dropped;
            end
        end
        e.out = model_out();
        e.cnt = 7'(mq.size());
        e.vld = (mq.size() >= 32);
        e.epb = mepb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rbsp_out", 64'(bus_if.rbsp_out), 64'(e.out));
        chk("bit_count", 64'(bus_if.bit_count), 64'(e.cnt));
        chk("rbsp_buffer_valid", 64'(bus_if.rbsp_buffer_valid), 64'(e.vld));
        chk("epb_removed", 64'(epb_removed), 64'(e.epb));
    endtask

    task automatic feed(input logic [7:0] d);
        step(1'b1, 1'b0, 1'b1, d, 6'd0);
    endtask

    initial begin
        logic [7:0] pat3 [10];
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1; ena = 1'b0; flush = 1'b0;
        bus_if.stream_mem_valid = 1'b0;
        bus_if.stream_mem_data  = 8'h00;
        bus_if.forward_len      = 6'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_now("reset");
        chk("reset_out_zero", 64'(bus_if.rbsp_out), 64'h0);
        rst = 1'b0;
        ena = 1'b1;
        #1;
        chk("rd_empty_eq_ena", 64'(bus_if.stream_mem_rd), 64'h1);
        @(posedge clk);
        #1;

        // Four plain bytes fill the window
        feed(8'hAA); feed(8'hBB); feed(8'hCC);
        chk("t1_not_valid_yet", 64'(bus_if.rbsp_buffer_valid), 64'h0);
        feed(8'hDD);
        chk("t1_out", 64'(bus_if.rbsp_out), 64'hAABBCCDD);
        chk("t1_cnt", 64'(bus_if.bit_count), 64'd32);
        step(1'b1, 1'b0, 1'b0, 8'h00, 6'd32);

        // Single EPB removal
        feed(8'h00); feed(8'h00); feed(8'h03);
        chk("t2_epb_pulse", 64'(epb_removed), 64'h1);
        feed(8'h01);
        chk("t2_epb_one_cycle", 64'(epb_removed), 64'h0);
        feed(8'hFF);
        chk("t2_out", 64'(bus_if.rbsp_out), 64'h000001FF);
        chk("t2_cnt", 64'(bus_if.bit_count), 64'd32);
        step(1'b1, 1'b0, 1'b0, 8'h00, 6'd32);

        // Saturating zero run and a trailing 03 that is kept
        pat3 = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h00, 8'h00, 8'h03, 8'h03};
        for (int i = 0; i < 10; i++) feed(pat3[i]);
        chk("t3_cnt", 64'(bus_if.bit_count), 64'd64);
        chk("t3_out_hi", 64'(bus_if.rbsp_out), 64'h00000011);
        feed(8'h55);
        step(1'b1, 1'b0, 1'b0, 8'h00, 6'd32);
        chk("t3_out_lo", 64'(bus_if.rbsp_out), 64'h22000003);

        // Continuous supply with no consumption: stalls at 64 bits
        step(1'b1, 1'b1, 1'b1, 8'h77, 6'd0);
        for (int i = 0; i < 10; i++) feed(8'(i + 1));
        chk("t4_full_cnt", 64'(bus_if.bit_count), 64'd64);
        chk("t4_full_rd", 64'(bus_if.stream_mem_rd), 64'h0);

        // Consume and accept in the same cycle
        step(1'b1, 1'b1, 1'b0, 8'h00, 6'd0);
        feed(8'hAA); feed(8'hBB); feed(8'hCC); feed(8'hDD); feed(8'hEE);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 6'd5);
        chk("t5_cnt", 64'(bus_if.bit_count), 64'd43);
        chk("t5_out", 64'(bus_if.rbsp_out), 64'h57799BBD);

        // Freeze with ena low, with an EPB pulse outstanding
        step(1'b1, 1'b0, 1'b0, 8'h00, 6'd32);
        feed(8'h00); feed(8'h00); feed(8'h03);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h12, 6'd8);
        chk("t6_hold_epb", 64'(epb_removed), 64'h1);
        chk("t6_hold_cnt", 64'(bus_if.bit_count), 64'd27);

        // Flush clears the zero-run history
        feed(8'h00); feed(8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h03, 6'd0);
        chk("t7_flush_cnt", 64'(bus_if.bit_count), 64'd0);
        feed(8'h03);
        chk("t7_03_kept", 64'(bus_if.rbsp_out), 64'h03000000);
        feed(8'h00); feed(8'h00); feed(8'h03);
        chk("t7_03_dropped", 64'(epb_removed), 64'h1);

        // Forward length clamp and ignored consume when not valid
        feed(8'hAA); feed(8'hBB);
        step(1'b1, 1'b0, 1'b0, 8'h00, 6'd40);
        chk("t8_clamp_cnt", 64'(bus_if.bit_count), 64'd8);
        step(1'b1, 1'b0, 1'b0, 8'h00, 6'd8);
        chk("t8_ignore_cnt", 64'(bus_if.bit_count), 64'd8);

        // Asynchronous reset between clock edges
        feed(8'h5A);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_now("async_rst");
        chk("async_rst_cnt0", 64'(bus_if.bit_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        feed(8'h42);
        chk("post_rst_out", 64'(bus_if.rbsp_out), 64'h42000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_rbsp_epb_buffer
`default_nettype wire
